// File: rtl/bht_update_sched_if.sv
// Update-request and BHT-drain handshake bundle for bht_update_sched.
// slave is the scheduler side; master is the requester/BHT side.
interface bht_update_sched_if #(
    parameter int unsigned VLEN = 64
) ();
    logic [1:0]           req_valid_i;
    logic [1:0][VLEN-1:0] req_pc_i;
    logic [1:0]           req_taken_i;
    logic [1:0]           req_ready_o;
    logic                 upd_valid_o;
    logic [VLEN-1:0]      upd_pc_o;
    logic                 upd_taken_o;
    logic                 upd_ready_i;

    modport slave (
        input  req_valid_i, req_pc_i, req_taken_i, upd_ready_i,
        output req_ready_o, upd_valid_o, upd_pc_o, upd_taken_o
    );

    modport master (
        output req_valid_i, req_pc_i, req_taken_i, upd_ready_i,
        input  req_ready_o, upd_valid_o, upd_pc_o, upd_taken_o
    );
endinterface

// File: rtl/bht_update_sched.sv
// Gshare BHT update-port controller: clear sweep after reset/flush, two-port
// round-robin arbitration of branch updates, and a small drain FIFO.
module bht_update_sched #(
    parameter int unsigned NR_ENTRIES = 1024,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned VLEN       = 64,
    localparam int unsigned INDEX_BITS = $clog2(NR_ENTRIES)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  flush_i,
    input  logic                  debug_mode_i,
    bht_update_sched_if.slave     bus,
    output logic                  clr_valid_o,
    output logic [INDEX_BITS-1:0] clr_index_o,
    output logic                  init_busy_o,
    output logic [15:0]           drop_cnt_o
);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_e;

    state_e                state_r, state_s;
    logic [INDEX_BITS-1:0] index_r, index_s;

    logic [VLEN:0]         mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]      rd_ptr_r, wr_ptr_r;
    logic [CNT_W-1:0]      count_r;
    logic                  rr_r;
    logic [15:0]           drop_cnt_r;

    logic                  run_s, full_s, upd_valid_s, pop_s, can_acc_s;
    logic [1:0]            ready_s;
    logic                  hs_s, hs_port_s, push_s;
    logic [VLEN:0]         push_data_s;

    // State register and clear-sweep index
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r <= INIT;
            index_r <= {INDEX_BITS{1'b0}};
        end else begin
            state_r <= state_s;
            index_r <= index_s;
        end
    end

    // Next state: sweep every entry once, flush restarts the sweep from zero
    always_comb begin
        state_s = state_r;
        index_s = index_r;
        if (flush_i) begin
            state_s = INIT;
            index_s = {INDEX_BITS{1'b0}};
        end else begin
            case (state_r)
                INIT: begin
                    if (index_r == INDEX_BITS'(NR_ENTRIES - 1)) begin
                        state_s = RUN;
                        index_s = {INDEX_BITS{1'b0}};
                    end else begin
                        index_s = index_r + INDEX_BITS'(1);
                    end
                end
                RUN: begin
                    state_s = RUN;
                    index_s = {INDEX_BITS{1'b0}};
                end
                default: begin
                    state_s = INIT;
                    index_s = {INDEX_BITS{1'b0}};
                end
            endcase
        end
    end

    // Arbitration and FIFO control; a port's ready looks only at the other port's valid
    always_comb begin
        run_s       = (state_r == RUN);
        full_s      = (count_r == CNT_W'(FIFO_DEPTH));
        upd_valid_s = run_s & ~flush_i & (count_r != {CNT_W{1'b0}});
        pop_s       = upd_valid_s & bus.upd_ready_i;
        can_acc_s   = run_s & ~flush_i & (~full_s | pop_s);
        ready_s[0]  = can_acc_s & (~bus.req_valid_i[1] | ~rr_r);
        ready_s[1]  = can_acc_s & (~bus.req_valid_i[0] |  rr_r);
        hs_s        = |(bus.req_valid_i & ready_s);
        hs_port_s   = bus.req_valid_i[1] & ready_s[1];
        push_s      = hs_s & ~debug_mode_i;
        if (hs_port_s) begin
            push_data_s = {bus.req_pc_i[1], bus.req_taken_i[1]};
        end else begin
            push_data_s = {bus.req_pc_i[0], bus.req_taken_i[0]};
        end
    end

    // FIFO storage; reset clears it so the head reads zero out of reset
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                mem_r[i] <= {(VLEN + 1){1'b0}};
            end
        end else if (push_s) begin
            mem_r[wr_ptr_r] <= push_data_s;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at a power-of-two depth
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_ptr_r <= {PTR_W{1'b0}};
            wr_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else if (flush_i) begin
            rd_ptr_r <= {PTR_W{1'b0}};
            wr_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Round-robin pointer hands priority to the other port after a grant
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rr_r <= 1'b0;
        end else if (flush_i) begin
            rr_r <= 1'b0;
        end else if (hs_s) begin
            rr_r <= ~hs_port_s;
        end
    end

    // Debug-mode drop counter survives flush and saturates
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            drop_cnt_r <= 16'h0000;
        end else if (hs_s && debug_mode_i && (drop_cnt_r != 16'hFFFF)) begin
            drop_cnt_r <= drop_cnt_r + 16'h0001;
        end
    end

    assign bus.req_ready_o = ready_s;
    assign bus.upd_valid_o = upd_valid_s;
    assign bus.upd_pc_o    = mem_r[rd_ptr_r][VLEN:1];
    assign bus.upd_taken_o = mem_r[rd_ptr_r][0];
    assign clr_valid_o     = ~run_s;
    assign clr_index_o     = index_r;
    assign init_busy_o     = ~run_s;
    assign drop_cnt_o      = drop_cnt_r;
endmodule

// File: tb/tb_bht_update_sched.sv
// Directed bench for bht_update_sched with NR_ENTRIES=8, FIFO_DEPTH=4.
module tb_bht_update_sched;
    localparam int unsigned NR = 8;
    localparam int unsigned VL = 32;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       flush_i;
    logic       debug_mode_i;
    logic       clr_valid_o;
    logic [2:0] clr_index_o;
    logic       init_busy_o;
    logic [15:0] drop_cnt_o;

    int checks   = 0;
    int failures = 0;

    localparam logic [31:0] PA = 32'hA000_0000;
    localparam logic [31:0] PB = 32'hB000_0000;
    localparam logic [31:0] PC = 32'hC000_0000;
    localparam logic [31:0] PD = 32'hD000_0000;
    localparam logic [31:0] PE = 32'hE000_0000;

    bht_update_sched_if #(.VLEN(VL)) bus ();

    bht_update_sched #(.NR_ENTRIES(NR), .FIFO_DEPTH(4), .VLEN(VL)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .flush_i      (flush_i),
        .debug_mode_i (debug_mode_i),
        .bus          (bus),
        .clr_valid_o  (clr_valid_o),
        .clr_index_o  (clr_index_o),
        .init_busy_o  (init_busy_o),
        .drop_cnt_o   (drop_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        logic [31:0] exp_pc;
        logic        exp_tk;

        rst_i = 1'b1; flush_i = 1'b0; debug_mode_i = 1'b0;
        bus.req_valid_i = 2'b00; bus.req_pc_i = '0; bus.req_taken_i = 2'b00;
        bus.upd_ready_i = 1'b0;
        #1;
        check("rst_clr_valid", 64'(clr_valid_o), 64'd1);
        check("rst_clr_index", 64'(clr_index_o), 64'd0);
        check("rst_init_busy", 64'(init_busy_o), 64'd1);
        check("rst_req_ready", 64'(bus.req_ready_o), 64'd0);
        check("rst_upd_valid", 64'(bus.upd_valid_o), 64'd0);
        check("rst_upd_pc", 64'(bus.upd_pc_o), 64'd0);
        check("rst_upd_taken", 64'(bus.upd_taken_o), 64'd0);
        check("rst_drop_cnt", 64'(drop_cnt_o), 64'd0);
        step();
        rst_i = 1'b0;

        // clear sweep 0..7
        for (int i = 0; i < int'(NR); i++) begin
            #1;
            check("sweep_clr_valid", 64'(clr_valid_o), 64'd1);
            check("sweep_clr_index", 64'(clr_index_o), 64'(i));
            check("sweep_req_ready", 64'(bus.req_ready_o), 64'd0);
            step();
        end
        #1;
        check("run_init_busy", 64'(init_busy_o), 64'd0);
        check("run_clr_valid", 64'(clr_valid_o), 64'd0);
        check("run_req_ready_idle", 64'(bus.req_ready_o), 64'd3);
        check("run_upd_valid_idle", 64'(bus.upd_valid_o), 64'd0);

        // both ports streaming: grants alternate, drain order A0,B0,A1,B1
        bus.upd_ready_i = 1'b1;
        bus.req_taken_i = 2'b01;
        for (int k = 0; k < 4; k++) begin
            bus.req_valid_i = 2'b11;
            bus.req_pc_i[0] = PA + 32'((k + 1) / 2);
            bus.req_pc_i[1] = PB + 32'(k / 2);
            #1;
            check("rr_ready", 64'(bus.req_ready_o), (k % 2 == 0) ? 64'd1 : 64'd2);
            if (k >= 1) begin
                exp_pc = ((k - 1) % 2 == 0) ? PA + 32'((k - 1) / 2) : PB + 32'((k - 1) / 2);
                exp_tk = ((k - 1) % 2 == 0) ? 1'b1 : 1'b0;
                check("rr_upd_valid", 64'(bus.upd_valid_o), 64'd1);
                check("rr_upd_pc", 64'(bus.upd_pc_o), 64'(exp_pc));
                check("rr_upd_taken", 64'(bus.upd_taken_o), 64'(exp_tk));
            end
            step();
        end
        bus.req_valid_i = 2'b00;
        #1;
        check("rr_last_valid", 64'(bus.upd_valid_o), 64'd1);
        check("rr_last_pc", 64'(bus.upd_pc_o), 64'(PB + 32'd1));
        check("rr_last_taken", 64'(bus.upd_taken_o), 64'd0);
        step();
        check("rr_drained", 64'(bus.upd_valid_o), 64'd0);

        // port 0 fills the FIFO while the BHT stalls
        bus.upd_ready_i = 1'b0;
        bus.req_valid_i = 2'b01;
        for (int j = 0; j < 4; j++) begin
            bus.req_pc_i[0] = PC + 32'(j);
            bus.req_taken_i[0] = 1'(j % 2);
            #1;
            check("fill_ready", 64'(bus.req_ready_o[0]), 64'd1);
            step();
        end
        bus.req_pc_i[0] = PC + 32'd4;
        bus.req_taken_i[0] = 1'b0;
        #1;
        check("full_ready", 64'(bus.req_ready_o[0]), 64'd0);
        check("full_upd_valid", 64'(bus.upd_valid_o), 64'd1);
        check("full_upd_pc", 64'(bus.upd_pc_o), 64'(PC));
        step();
        check("full_hold_ready", 64'(bus.req_ready_o[0]), 64'd0);
        bus.upd_ready_i = 1'b1;
        #1;
        check("full_pop_ready", 64'(bus.req_ready_o[0]), 64'd1);
        check("full_pop_pc0", 64'(bus.upd_pc_o), 64'(PC));
        step();
        bus.req_pc_i[0] = PC + 32'd5;
        bus.req_taken_i[0] = 1'b1;
        #1;
        check("full_pop_ready2", 64'(bus.req_ready_o[0]), 64'd1);
        check("full_pop_pc1", 64'(bus.upd_pc_o), 64'(PC + 32'd1));
        step();
        bus.req_valid_i = 2'b00;
        for (int j = 2; j < 6; j++) begin
            #1;
            check("drain_valid", 64'(bus.upd_valid_o), 64'd1);
            check("drain_pc", 64'(bus.upd_pc_o), 64'(PC + 32'(j)));
            check("drain_taken", 64'(bus.upd_taken_o), 64'(j % 2));
            step();
        end
        check("drain_empty", 64'(bus.upd_valid_o), 64'd0);

        // debug mode: acknowledged but dropped
        debug_mode_i = 1'b1;
        bus.req_valid_i = 2'b10;
        bus.req_pc_i[1] = PE;
        for (int j = 0; j < 3; j++) begin
            #1;
            check("dbg_ready", 64'(bus.req_ready_o[1]), 64'd1);
            check("dbg_no_upd", 64'(bus.upd_valid_o), 64'd0);
            step();
        end
        bus.req_valid_i = 2'b00;
        #1;
        check("dbg_drop3", 64'(drop_cnt_o), 64'd3);
        check("dbg_no_upd_after", 64'(bus.upd_valid_o), 64'd0);
        bus.req_valid_i = 2'b11;
        repeat (65540) step();
        bus.req_valid_i = 2'b00;
        #1;
        check("dbg_drop_sat", 64'(drop_cnt_o), 64'hFFFF);
        check("dbg_sat_no_upd", 64'(bus.upd_valid_o), 64'd0);
        debug_mode_i = 1'b0;
        step();

        // flush discards queued updates and restarts the sweep
        bus.upd_ready_i = 1'b0;
        bus.req_valid_i = 2'b01;
        bus.req_pc_i[0] = PD;
        step();
        bus.req_pc_i[0] = PD + 32'd1;
        step();
        flush_i = 1'b1;
        bus.req_valid_i = 2'b11;
        #1;
        check("flush_ready", 64'(bus.req_ready_o), 64'd0);
        check("flush_no_pop", 64'(bus.upd_valid_o), 64'd0);
        step();
        flush_i = 1'b0;
        bus.req_valid_i = 2'b00;
        bus.upd_ready_i = 1'b1;
        #1;
        check("flush_clr_valid", 64'(clr_valid_o), 64'd1);
        check("flush_clr_index", 64'(clr_index_o), 64'd0);
        check("flush_init_busy", 64'(init_busy_o), 64'd1);
        check("flush_upd_valid", 64'(bus.upd_valid_o), 64'd0);
        check("flush_keeps_drop", 64'(drop_cnt_o), 64'hFFFF);
        step();
        step();
        step();
        check("sweep2_index3", 64'(clr_index_o), 64'd3);
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        #1;
        check("reflush_index0", 64'(clr_index_o), 64'd0);
        repeat (8) step();
        check("post_flush_run", 64'(init_busy_o), 64'd0);
        check("post_flush_empty", 64'(bus.upd_valid_o), 64'd0);
        bus.req_valid_i = 2'b11;
        #1;
        check("post_flush_rr0", 64'(bus.req_ready_o), 64'd1);
        bus.req_valid_i = 2'b00;
        #1;

        // asynchronous reset at sweep index 5
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        repeat (5) step();
        check("pre_rst_index5", 64'(clr_index_o), 64'd5);
        #1;
        rst_i = 1'b1;
        #1;
        check("arst_clr_index", 64'(clr_index_o), 64'd0);
        check("arst_clr_valid", 64'(clr_valid_o), 64'd1);
        check("arst_drop_cnt", 64'(drop_cnt_o), 64'd0);
        check("arst_upd_valid", 64'(bus.upd_valid_o), 64'd0);
        check("arst_upd_pc", 64'(bus.upd_pc_o), 64'd0);
        check("arst_req_ready", 64'(bus.req_ready_o), 64'd0);
        step();
        rst_i = 1'b0;
        repeat (8) step();
        check("arst_run", 64'(init_busy_o), 64'd0);
        check("arst_fifo_empty", 64'(bus.upd_valid_o), 64'd0);
        check("arst_ready_idle", 64'(bus.req_ready_o), 64'd3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
